riscv_ex_stage: RTL and testbench
=================================

# riscv_ex_stage

Execute-stage block of the five-stage RV32I pipeline: load-use hazard detection, ALU operand forwarding/selection, the integer ALU with branch-condition evaluation, branch-target computation and the EX/MEM result register. It sits between the ID/EX pipeline register and data memory. It combines the hazard-detection, operand-source and ALU functions in one unit.

## Interface
Parameters: none.
- `clock`  in  1  pipeline clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `EX_signals`  in  11  control word; bit 2 AluSrc, bit 5 MemRead, bits 10:8 AluOp. Other bits are ignored.
- `EX_dataA`, `EX_dataB`  in  32  register-file operands.
- `EX_immGenOut`  in  32  sign-extended immediate.
- `EX_imemAddr`  in  32  word-addressed PC of the instruction.
- `EX_func3_7`  in  4  {instr[30], funct3}.
- `EX_Rd`  in  5  destination register of the instruction in EX.
- `ID_Rs1`, `ID_Rs2`  in  5  source registers of the instruction in ID.
- `forwardA`, `forwardB`  in  2  forwarding selects.
- `dataD`  in  32  writeback-stage result.
- `notStall`  out  1  0 requests a one-cycle stall of PC and IF/ID.
- `aluResult`  out  32  combinational ALU result.
- `branchFromAlu`  out  1  combinational branch condition.
- `MEM_aluResult`  out  32  registered ALU result.
- `MEM_branchFromAlu`  out  1  registered branch condition.
- `MEM_branchAddr`  out  32  registered branch target.
- `MEM_dataB`  out  32  registered store data.

## Operation
- **Hazard detection.** `notStall` = !(`EX_signals[5]` && (`EX_Rd`==`ID_Rs1` || `EX_Rd`==`ID_Rs2`)). It is purely combinational. See Configuration for the x0 qualifier.
- **Operand A select** (by `forwardA`):
  - 00: `EX_dataA`
  - 10: `MEM_aluResult` (the internal register)
  - 01: `dataD`
  - 11: `EX_dataA`
- **Store data** `forwardB_dataB` (internal signal): selected by `forwardB` with the same encoding, starting from `EX_dataB`.
- **Operand B:** `EX_immGenOut` if `EX_signals[2]` is 1, otherwise `forwardB_dataB`.
- **ALU operations by AluOp** (f = `EX_func3_7`):
  - 000: A+B (load/store address).
  - 001: branch. Result = A−B. `branchFromAlu` by funct3:
    - 000 BEQ A==B
    - 001 BNE A!=B
    - 100 BLT signed A<B
    - 101 BGE signed A>=B
    - 110 BLTU unsigned A<B
    - 111 BGEU unsigned A>=B
    - 010, 011 → 0
  - 010: R-type, by funct3:
    - 000: ADD, or SUB when f[3]=1
    - 001: SLL
    - 010: SLT (signed)
    - 011: SLTU
    - 100: XOR
    - 101: SRL, or SRA when f[3]=1
    - 110: OR
    - 111: AND
  - 011: I-type. Same table as R-type, except f[3] is ignored for funct3 000 (always ADD). f[3] still selects SRAI for funct3 101.
  - 100: result = B (LUI).
  - 101–111: result = 0.
- `branchFromAlu` is 0 for every AluOp other than 001.
- Shift amount is B[4:0]. SLT/SLTU produce 32'd1 or 32'd0.
- All arithmetic is modulo 2^32; overflow is ignored.
- **Branch target:** `EX_imemAddr` + (`EX_immGenOut` >>> 2), with an arithmetic shift and 32-bit wrap.

## Timing
- `notStall`, `aluResult` and `branchFromAlu` are combinational and valid in the same cycle as their inputs.
- On each rising `clock`, the register captures `aluResult`, `branchFromAlu`, the branch target and `forwardB_dataB` into the MEM_* outputs. Latency is 1 cycle.
- No enable input: the register loads every cycle.
- `clear` low forces all MEM_* outputs to 0 immediately, regardless of `clock`, and holds them at 0 while low.
  - The first rising edge after `clear` deasserts loads normally.
  - Reset asserted in the middle of the pipeline discards the in-flight result.
- Forward select 10 returns the previous cycle's registered result, i.e. the instruction one ahead in the pipeline. Immediately after reset this value is 0.
- A simultaneous rising edge and `clear` low: reset wins.

## Configuration
- `HDU_X0_FILTER_EN` defined: the stall condition additionally requires `EX_Rd` != 0, so a load to x0 never stalls.
- Undefined: the stall is raised for any Rd match, including x0.

## Test plan
- **R-type SUB:** AluOp=010, f=4'b1000, A=5, B=7 → `aluResult`=32'hFFFFFFFE; `MEM_aluResult` equals that value after the next edge.
- **BNE:** AluOp=001, f=4'b0001, A=1, B=2, imm=8, PC=2 → `branchFromAlu`=1; `MEM_branchAddr`=4 after the edge.
- **Signed vs unsigned compare:** SLT and SLTU with A=32'hFFFFFFFF, B=1 → 1 and 0 respectively. BGEU with the same operands → `branchFromAlu`=1.
- **Forwarding:**
  - `forwardA`=10 with prior `aluResult`=9 registered → A=9.
  - `forwardA`=01 with `dataD`=3 → A=3.
  - `forwardB`=10 with AluSrc=1 → B=imm, but `MEM_dataB` takes the forwarded value.
- **Load-use stall:**
  - MemRead=1, `EX_Rd`=5, `ID_Rs2`=5 → `notStall`=0.
  - `EX_Rd`=6 → `notStall`=1.
  - `EX_Rd`=0 with `ID_Rs1`=0 → `notStall`=1 only when `HDU_X0_FILTER_EN` is defined.
- **Async reset:** pull `clear` low mid-cycle with nonzero MEM_* values → all MEM_* read 0 before the next clock edge.

Source files
------------

// File: rtl/riscv_ex_stage.sv
// RV32I execute stage: load-use hazard detect, operand forwarding, ALU, branch target, EX/MEM register.
// Define HDU_X0_FILTER_EN to suppress load-use stalls when the load targets x0.
module riscv_ex_stage (
    input  logic        clock,
    input  logic        clear,
    input  logic [10:0] EX_signals,
    input  logic [31:0] EX_dataA,
    input  logic [31:0] EX_dataB,
    input  logic [31:0] EX_immGenOut,
    input  logic [31:0] EX_imemAddr,
    input  logic [3:0]  EX_func3_7,
    input  logic [4:0]  EX_Rd,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic [31:0] dataD,
    output logic        notStall,
    output logic [31:0] aluResult,
    output logic        branchFromAlu,
    output logic [31:0] MEM_aluResult,
    output logic        MEM_branchFromAlu,
    output logic [31:0] MEM_branchAddr,
    output logic [31:0] MEM_dataB
);

    typedef enum logic [2:0] {
        OP_ADDR   = 3'b000,
        OP_BRANCH = 3'b001,
        OP_RTYPE  = 3'b010,
        OP_ITYPE  = 3'b011,
        OP_LUI    = 3'b100
    } alu_op_e;

    logic        alu_src;
    logic        mem_read;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic        alt;
    logic        unused_ctrl;

    assign alu_src     = EX_signals[2];
    assign mem_read    = EX_signals[5];
    assign alu_op      = EX_signals[10:8];
    assign funct3      = EX_func3_7[2:0];
    assign alt         = EX_func3_7[3];
    assign unused_ctrl = ^{EX_signals[7:6], EX_signals[4:3], EX_signals[1:0]};

    logic rd_match;
    assign rd_match = (EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2);
`ifdef HDU_X0_FILTER_EN
    assign notStall = !(mem_read && rd_match && (EX_Rd != 5'd0));
`else
    assign notStall = !(mem_read && rd_match);
`endif

    logic [31:0] alu_q, alu_d;
    logic        br_q, br_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] dataB_q, dataB_d;

    logic [31:0] op_a, forwardB_dataB, op_b;

    always_comb begin
        case (forwardA)
            2'b10:   op_a = alu_q;
            2'b01:   op_a = dataD;
            default: op_a = EX_dataA;
        endcase
        case (forwardB)
            2'b10:   forwardB_dataB = alu_q;
            2'b01:   forwardB_dataB = dataD;
            default: forwardB_dataB = EX_dataB;
        endcase
        op_b = alu_src ? EX_immGenOut : forwardB_dataB;
    end

    logic        eq, lt_s, lt_u, sub_sel;
    logic [4:0]  shamt;
    logic [31:0] arith;

    assign eq    = (op_a == op_b);
    assign lt_s  = ($signed(op_a) < $signed(op_b));
    assign lt_u  = (op_a < op_b);
    assign shamt = op_b[4:0];
    // Only register-register ops honour instr[30] as SUB; ADDI has no subtract form.
    assign sub_sel = (alu_op == OP_RTYPE) && alt;

    always_comb begin
        arith = '0;
        case (funct3)
            3'b000:  arith = sub_sel ? (op_a - op_b) : (op_a + op_b);
            3'b001:  arith = op_a << shamt;
            3'b010:  arith = {31'd0, lt_s};
            3'b011:  arith = {31'd0, lt_u};
            3'b100:  arith = op_a ^ op_b;
            3'b101:  arith = alt ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
            3'b110:  arith = op_a | op_b;
            default: arith = op_a & op_b;
        endcase
    end

    always_comb begin
        aluResult     = '0;
        branchFromAlu = 1'b0;
        case (alu_op)
            OP_ADDR:   aluResult = op_a + op_b;
            OP_BRANCH: begin
                aluResult = op_a - op_b;
                case (funct3)
                    3'b000:  branchFromAlu = eq;
                    3'b001:  branchFromAlu = !eq;
                    3'b100:  branchFromAlu = lt_s;
                    3'b101:  branchFromAlu = !lt_s;
                    3'b110:  branchFromAlu = lt_u;
                    3'b111:  branchFromAlu = !lt_u;
                    default: branchFromAlu = 1'b0;
                endcase
            end
            OP_RTYPE,
            OP_ITYPE:  aluResult = arith;
            OP_LUI:    aluResult = op_b;
            default:   aluResult = '0;
        endcase
    end

    // PC is word-addressed, so the byte offset is scaled down before adding.
    always_comb begin
        alu_d   = aluResult;
        br_d    = branchFromAlu;
        baddr_d = EX_imemAddr + 32'($signed(EX_immGenOut) >>> 2);
        dataB_d = forwardB_dataB;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            alu_q   <= '0;
            br_q    <= 1'b0;
            baddr_q <= '0;
            dataB_q <= '0;
        end else begin
            alu_q   <= alu_d;
            br_q    <= br_d;
            baddr_q <= baddr_d;
            dataB_q <= dataB_d;
        end
    end

    assign MEM_aluResult     = alu_q;
    assign MEM_branchFromAlu = br_q;
    assign MEM_branchAddr    = baddr_q;
    assign MEM_dataB         = dataB_q;

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Directed self-checking bench for riscv_ex_stage with hand-computed expectations.
module tb_riscv_ex_stage;

    logic        clock = 1'b0;
    logic        clear;
    logic [10:0] EX_signals;
    logic [31:0] EX_dataA, EX_dataB, EX_immGenOut, EX_imemAddr;
    logic [3:0]  EX_func3_7;
    logic [4:0]  EX_Rd, ID_Rs1, ID_Rs2;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] dataD;
    logic        notStall;
    logic [31:0] aluResult;
    logic        branchFromAlu;
    logic [31:0] MEM_aluResult;
    logic        MEM_branchFromAlu;
    logic [31:0] MEM_branchAddr;
    logic [31:0] MEM_dataB;

    int tests = 0;
    int fails = 0;

    riscv_ex_stage dut (
        .clock(clock), .clear(clear), .EX_signals(EX_signals),
        .EX_dataA(EX_dataA), .EX_dataB(EX_dataB), .EX_immGenOut(EX_immGenOut),
        .EX_imemAddr(EX_imemAddr), .EX_func3_7(EX_func3_7), .EX_Rd(EX_Rd),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .forwardA(forwardA), .forwardB(forwardB),
        .dataD(dataD), .notStall(notStall), .aluResult(aluResult),
        .branchFromAlu(branchFromAlu), .MEM_aluResult(MEM_aluResult),
        .MEM_branchFromAlu(MEM_branchFromAlu), .MEM_branchAddr(MEM_branchAddr),
        .MEM_dataB(MEM_dataB)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ignored control bits are driven high to confirm they have no effect.
    task automatic drive(input logic [2:0] op, input logic src, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
        EX_signals   = {op, 2'b11, 1'b0, 2'b11, src, 2'b11};
        EX_func3_7   = f;
        EX_dataA     = a;
        EX_dataB     = b;
        EX_immGenOut = imm;
        EX_imemAddr  = pc;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear = 1'b0;
        forwardA = 2'b00; forwardB = 2'b00; dataD = '0;
        EX_Rd = '0; ID_Rs1 = 5'd1; ID_Rs2 = 5'd2;
        drive(3'b000, 1'b0, 4'h0, 32'd11, 32'd22, 32'd40, 32'd7);
        #12;
        chk("rst_alu",   MEM_aluResult, 32'd0);
        chk("rst_br",    {31'd0, MEM_branchFromAlu}, 32'd0);
        chk("rst_baddr", MEM_branchAddr, 32'd0);
        chk("rst_dataB", MEM_dataB, 32'd0);

        clear = 1'b1;
        // forward select 10 right after reset returns the cleared register
        forwardA = 2'b10;
        drive(3'b000, 1'b0, 4'h0, 32'd100, 32'd7, 32'd0, 32'd0);
        #1;
        chk("fwdA10_after_rst", aluResult, 32'd7);
        forwardA = 2'b00;
        next_cycle();

        drive(3'b010, 1'b0, 4'b1000, 32'd5, 32'd7, 32'd0, 32'd0);
        #1;
        chk("sub_comb", aluResult, 32'hFFFFFFFE);
        chk("sub_nobr", {31'd0, branchFromAlu}, 32'd0);
        next_cycle();
        chk("sub_reg",   MEM_aluResult, 32'hFFFFFFFE);
        chk("sub_dataB", MEM_dataB, 32'd7);

        drive(3'b001, 1'b0, 4'b0001, 32'd1, 32'd2, 32'd8, 32'd2);
        #1;
        chk("bne_br",  {31'd0, branchFromAlu}, 32'd1);
        chk("bne_res", aluResult, 32'hFFFFFFFF);
        next_cycle();
        chk("bne_baddr", MEM_branchAddr, 32'd4);
        chk("bne_brreg", {31'd0, MEM_branchFromAlu}, 32'd1);

        drive(3'b001, 1'b0, 4'b0000, 32'd9, 32'd9, 32'hFFFFFFF8, 32'd10);
        #1;
        chk("beq_eq", {31'd0, branchFromAlu}, 32'd1);
        next_cycle();
        chk("baddr_neg", MEM_branchAddr, 32'd8);

        drive(3'b010, 1'b0, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        #1; chk("slt", aluResult, 32'd1);
        EX_func3_7 = 4'b0011;
        #1; chk("sltu", aluResult, 32'd0);
        drive(3'b001, 1'b0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        #1; chk("bgeu", {31'd0, branchFromAlu}, 32'd1);
        EX_func3_7 = 4'b0100;
        #1; chk("blt", {31'd0, branchFromAlu}, 32'd1);
        EX_func3_7 = 4'b0101;
        #1; chk("bge", {31'd0, branchFromAlu}, 32'd0);
        EX_func3_7 = 4'b0010;
        #1; chk("br_f010", {31'd0, branchFromAlu}, 32'd0);

        drive(3'b011, 1'b1, 4'b1000, 32'd5, 32'd99, 32'd3, 32'd0);
        #1; chk("addi_alt", aluResult, 32'd8);
        drive(3'b011, 1'b1, 4'b1101, 32'h80000000, 32'd0, 32'd4, 32'd0);
        #1; chk("srai", aluResult, 32'hF8000000);
        drive(3'b010, 1'b0, 4'b0101, 32'h80000000, 32'd4, 32'd0, 32'd0);
        #1; chk("srl", aluResult, 32'h08000000);
        drive(3'b010, 1'b0, 4'b0001, 32'h00000003, 32'd33, 32'd0, 32'd0);
        #1; chk("sll_shamt", aluResult, 32'h00000006);
        drive(3'b100, 1'b1, 4'b0000, 32'd1, 32'd2, 32'h12345000, 32'd0);
        #1; chk("lui", aluResult, 32'h12345000);
        drive(3'b101, 1'b0, 4'b0000, 32'd1, 32'd2, 32'd0, 32'd0);
        #1; chk("op101", aluResult, 32'd0);

        drive(3'b000, 1'b0, 4'h0, 32'd4, 32'd5, 32'd0, 32'd0);
        next_cycle();
        chk("fwd_prep", MEM_aluResult, 32'd9);
        drive(3'b000, 1'b0, 4'h0, 32'd100, 32'd0, 32'd0, 32'd0);
        forwardA = 2'b10;
        #1; chk("fwdA10", aluResult, 32'd9);
        forwardA = 2'b01; dataD = 32'd3;
        #1; chk("fwdA01", aluResult, 32'd3);
        forwardA = 2'b11;
        #1; chk("fwdA11", aluResult, 32'd100);
        forwardA = 2'b00; forwardB = 2'b01;
        #1; chk("fwdB01", aluResult, 32'd103);
        drive(3'b000, 1'b1, 4'h0, 32'd1, 32'd55, 32'd20, 32'd0);
        forwardB = 2'b10;
        #1; chk("fwdB10_imm", aluResult, 32'd21);
        next_cycle();
        chk("fwdB10_store", MEM_dataB, 32'd9);
        chk("fwdB10_alu",   MEM_aluResult, 32'd21);
        forwardB = 2'b00;

        EX_signals = 11'h020; EX_Rd = 5'd5; ID_Rs1 = 5'd1; ID_Rs2 = 5'd5;
        #1; chk("stall_rs2", {31'd0, notStall}, 32'd0);
        EX_Rd = 5'd6;
        #1; chk("nostall_rd6", {31'd0, notStall}, 32'd1);
        EX_Rd = 5'd1;
        #1; chk("stall_rs1", {31'd0, notStall}, 32'd0);
        EX_signals = 11'h000;
        #1; chk("nostall_noload", {31'd0, notStall}, 32'd1);
        EX_signals = 11'h020; EX_Rd = 5'd0; ID_Rs1 = 5'd0;
`ifdef HDU_X0_FILTER_EN
        #1; chk("x0_stall", {31'd0, notStall}, 32'd1);
`else
        #1; chk("x0_stall", {31'd0, notStall}, 32'd0);
`endif

        drive(3'b001, 1'b0, 4'b0001, 32'd3, 32'd4, 32'd16, 32'd100);
        next_cycle();
        chk("pre_rst_alu", MEM_aluResult, 32'hFFFFFFFF);
        #2;
        clear = 1'b0;
        #1;
        chk("async_alu",   MEM_aluResult, 32'd0);
        chk("async_br",    {31'd0, MEM_branchFromAlu}, 32'd0);
        chk("async_baddr", MEM_branchAddr, 32'd0);
        chk("async_dataB", MEM_dataB, 32'd0);
        next_cycle();
        chk("rst_hold", MEM_branchAddr, 32'd0);
        #3;
        clear = 1'b1;
        drive(3'b000, 1'b0, 4'h0, 32'd2, 32'd3, 32'd0, 32'd0);
        next_cycle();
        chk("post_rst_load", MEM_aluResult, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
